// File: rtl/led_frame_loader.sv
// Shadow-buffers a frame of brightness words and copies it into the active PWM duty
// registers on a period boundary. Define LED_FRAME_COUNT_EN to add the frameCount output.
module led_frame_loader #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DATA_W   = 12
) (
  input  logic                       oscillator,
  input  logic                       globalResetN,
  input  logic [DATA_W-1:0]          dataIn,
  input  logic                       dataFirst,
  input  logic                       dataValid,
  output logic                       dataReady,
  input  logic                       periodStart,
  input  logic                       clearError,
  output logic [CHANNELS*DATA_W-1:0] LEDFrameData,
  output logic                       frameSwap,
  output logic                       framePending,
  output logic                       syncError
`ifdef LED_FRAME_COUNT_EN
  ,
  output logic [7:0]                 frameCount
`endif
);

  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNELS - 1);

  typedef enum logic [0:0] {StFill, StPending} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic [DATA_W-1:0] shadow_q [CHANNELS];
  logic [DATA_W-1:0] active_q [CHANNELS];
  logic              sync_error_q, sync_error_d;
  logic              frame_swap_q;
  logic              transfer, shadow_we, swap, err_set;
  logic [IdxW-1:0]   shadow_sel;

  assign dataReady    = (state_q == StFill);
  assign framePending = (state_q == StPending);
  assign transfer     = dataValid & dataReady;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    shadow_we  = 1'b0;
    shadow_sel = index_q;
    swap       = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      StFill: begin
        if (transfer) begin
          if (dataFirst) begin
            // A new start-of-frame abandons any partial frame.
            shadow_we  = 1'b1;
            shadow_sel = '0;
            err_set    = (index_q != '0);
          end else if (index_q != '0) begin
            shadow_we = 1'b1;
          end else begin
            err_set = 1'b1;
          end
          if (shadow_we) begin
            if (shadow_sel == LastIdx) begin
              index_d = '0;
              state_d = StPending;
            end else begin
              index_d = shadow_sel + IdxW'(1);
            end
          end
        end
      end
      StPending: begin
        if (periodStart) begin
          swap    = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
    if (err_set) begin
      sync_error_d = 1'b1;
    end else if (clearError) begin
      sync_error_d = 1'b0;
    end else begin
      sync_error_d = sync_error_q;
    end
  end

  always_ff @(posedge oscillator or negedge globalResetN) begin
    if (!globalResetN) begin
      state_q      <= StFill;
      index_q      <= '0;
      sync_error_q <= 1'b0;
      frame_swap_q <= 1'b0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      sync_error_q <= sync_error_d;
      frame_swap_q <= swap;
      if (shadow_we) begin
        shadow_q[shadow_sel] <= dataIn;
      end
      if (swap) begin
        active_q <= shadow_q;
      end
    end
  end

  for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_out
    assign LEDFrameData[k*DATA_W +: DATA_W] = active_q[k];
  end

  assign frameSwap = frame_swap_q;
  assign syncError = sync_error_q;

`ifdef LED_FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge oscillator or negedge globalResetN) begin
    if (!globalResetN) begin
      frame_count_q <= '0;
    end else if (swap) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frameCount = frame_count_q;
`else
  // Without the counter, swaps are observable only through frameSwap.
`endif

endmodule

// File: tb/tb_led_frame_loader.sv
// Randomized and directed bench for led_frame_loader against a frame-level reference model.
// Honours LED_FRAME_COUNT_EN to also check frameCount.
module tb_led_frame_loader;
  localparam int CH = 4;
  localparam int DW = 12;

  logic oscillator = 1'b0;
  logic globalResetN;
  logic [DW-1:0] dataIn;
  logic dataFirst, dataValid, dataReady, periodStart, clearError;
  logic [CH*DW-1:0] LEDFrameData;
  logic frameSwap, framePending, syncError;
`ifdef LED_FRAME_COUNT_EN
  logic [7:0] frameCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words collected so far, whether a whole frame is waiting.
  logic [DW-1:0] m_shadow [CH];
  logic [DW-1:0] m_active [CH];
  int m_fill;
  bit m_full, m_swap, m_err;
  int m_count;

  led_frame_loader #(.CHANNELS(CH), .DATA_W(DW)) dut (
    .oscillator  (oscillator),
    .globalResetN(globalResetN),
    .dataIn      (dataIn),
    .dataFirst   (dataFirst),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .periodStart (periodStart),
    .clearError  (clearError),
    .LEDFrameData(LEDFrameData),
    .frameSwap   (frameSwap),
    .framePending(framePending),
    .syncError   (syncError)
`ifdef LED_FRAME_COUNT_EN
    ,
    .frameCount  (frameCount)
`endif
  );

  always #5 oscillator = ~oscillator;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_fill = 0; m_full = 0; m_swap = 0; m_err = 0; m_count = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit set_err = 0;
    m_swap = 0;
    if (m_full) begin
      if (periodStart) begin
        m_active = m_shadow;
        m_full   = 0;
        m_swap   = 1;
        m_count  = (m_count + 1) % 256;
      end
    end else if (dataValid) begin
      if (dataFirst) begin
        if (m_fill != 0) set_err = 1;
        m_shadow[0] = dataIn;
        m_fill = 1;
      end else if (m_fill == 0) begin
        set_err = 1;
      end else begin
        m_shadow[m_fill] = dataIn;
        m_fill++;
      end
      if (m_fill == CH) begin
        m_full = 1;
        m_fill = 0;
      end
    end
    if (set_err) m_err = 1;
    else if (clearError) m_err = 0;
  endtask

  function automatic logic [CH*DW-1:0] model_leds();
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = m_active[k];
    return v;
  endfunction

  task automatic check_outputs();
    check("leds",    64'(LEDFrameData), 64'(model_leds()));
    check("ready",   64'(dataReady),    64'(!m_full));
    check("pending", 64'(framePending), 64'(m_full));
    check("swap",    64'(frameSwap),    64'(m_swap));
    check("syncerr", 64'(syncError),    64'(m_err));
`ifdef LED_FRAME_COUNT_EN
    check("count",   64'(frameCount),   64'(m_count));
`endif
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs checked 1 unit after the next.
  task automatic cycle();
    model_step();
    @(posedge oscillator);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [DW-1:0] d, input bit f, input bit v, input bit ps,
                       input bit ce);
    dataIn = d; dataFirst = f; dataValid = v; periodStart = ps; clearError = ce;
    cycle();
  endtask

  task automatic send_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    drive(w0, 1, 1, 0, 0);
    drive(w1, 0, 1, 0, 0);
    drive(w2, 0, 1, 0, 0);
    drive(w3, 0, 1, 0, 0);
  endtask

  task automatic pulse_reset();
    globalResetN = 1'b0;
    #1;
    model_reset();
    check_outputs();
    dataIn = '0; dataFirst = 0; dataValid = 0; periodStart = 0; clearError = 0;
    @(posedge oscillator);
    #1;
    globalResetN = 1'b1;
  endtask

  initial begin
    logic [CH*DW-1:0] exp_frame;
    globalResetN = 1'b0;
    dataIn = '0; dataFirst = 0; dataValid = 0; periodStart = 0; clearError = 0;
    model_reset();
    repeat (2) @(posedge oscillator);
    #1;
    check_outputs();
    globalResetN = 1'b1;

    // Idle with period pulses: nothing to swap.
    for (int i = 0; i < 8; i++) drive('0, 0, 0, (i % 2) == 1, 0);

    // Boundary values through one frame.
    send_frame(12'h000, 12'h7FF, 12'h800, 12'hFFF);
    check("pend_after_4", 64'(framePending), 64'd1);
    drive('0, 0, 0, 1, 0);
    exp_frame = {12'hFFF, 12'h800, 12'h7FF, 12'h000};
    check("frame_const", 64'(LEDFrameData), 64'(exp_frame));
    check("swap_pulse", 64'(frameSwap), 64'd1);
    check("ready_after_swap", 64'(dataReady), 64'd1);
    drive('0, 0, 0, 0, 0);
    check("swap_one_cycle", 64'(frameSwap), 64'd0);

    // Valid held while a frame is pending: nothing consumed until after the swap.
    send_frame(12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4);
    for (int i = 0; i < 10; i++) drive(12'h123, 1, 1, 0, 0);
    check("held_ready", 64'(dataReady), 64'd0);
    drive(12'h123, 1, 1, 1, 0);
    drive(12'h123, 1, 1, 0, 0);
    drive(12'h456, 0, 1, 0, 0);
    drive(12'h789, 0, 1, 0, 0);
    drive(12'hABC, 0, 1, 0, 0);
    drive('0, 0, 0, 1, 0);
    check("held_word_ch0", 64'(LEDFrameData[DW-1:0]), 64'h123);
    check("held_word_ch3", 64'(LEDFrameData[3*DW +: DW]), 64'hABC);

    // Restart mid-frame raises the sticky error; clearError drops it.
    drive(12'h111, 1, 1, 0, 0);
    drive(12'h222, 0, 1, 0, 0);
    drive(12'h333, 1, 1, 0, 0);
    check("sync_err_set", 64'(syncError), 64'd1);
    drive('0, 0, 0, 0, 0);
    drive('0, 0, 0, 0, 1);
    check("sync_err_clr", 64'(syncError), 64'd0);
    drive(12'h444, 0, 1, 0, 0);
    drive(12'h555, 0, 1, 0, 0);
    drive(12'h666, 0, 1, 0, 0);
    drive('0, 0, 0, 1, 0);
    check("restart_ch0", 64'(LEDFrameData[DW-1:0]), 64'h333);

    // Error set and clear in the same cycle: set wins.
    drive(12'h001, 0, 1, 0, 1);
    check("set_beats_clear", 64'(syncError), 64'd1);
    drive('0, 0, 0, 0, 1);

    // Last word together with periodStart: swap waits for the next period.
    drive(12'h010, 1, 1, 0, 0);
    drive(12'h020, 0, 1, 0, 0);
    drive(12'h030, 0, 1, 0, 0);
    drive(12'h040, 0, 1, 1, 0);
    check("no_swap_coincident", 64'(frameSwap), 64'd0);
    for (int i = 0; i < 4095; i++) drive('0, 0, 0, 0, 0);
    drive('0, 0, 0, 1, 0);
    check("late_swap", 64'(frameSwap), 64'd1);

    // Reset after two words discards the partial frame.
    drive(12'h0F0, 1, 1, 0, 0);
    drive(12'h0F1, 0, 1, 0, 0);
    pulse_reset();
    check("rst_leds", 64'(LEDFrameData), 64'd0);
    drive(12'h0F2, 0, 1, 0, 0);
    check("rst_needs_first", 64'(syncError), 64'd1);
    drive('0, 0, 0, 0, 1);
    send_frame(12'h101, 12'h202, 12'h303, 12'h404);
    drive('0, 0, 0, 1, 0);

    // Randomized traffic; payload is held while stalled.
    for (int c = 0; c < 3000; c++) begin
      if (!(dataValid && !dataReady)) begin
        dataIn    = DW'($urandom);
        dataFirst = ($urandom_range(0, 4) == 0);
        dataValid = ($urandom_range(0, 9) < 7);
      end
      periodStart = ($urandom_range(0, 7) == 0);
      clearError  = ($urandom_range(0, 15) == 0);
      cycle();
    end

`ifdef LED_FRAME_COUNT_EN
    pulse_reset();
    for (int s = 0; s < 256; s++) begin
      send_frame(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      drive('0, 0, 0, 1, 0);
    end
    check("count_wrap", 64'(frameCount), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_frame_loader.md
Name: led_frame_loader

Overview:
- Upstream feeder for the per-LED PWM stage (12-bit free-running counter plus A<B comparator).
- Accepts a stream of 12-bit brightness words over a valid/ready handshake into a shadow buffer.
- Once a full frame is buffered, it copies the frame to the active registers at the next PWM period boundary, so a duty value never changes mid-period.
- Active registers drive the LEDFrameData inputs of CHANNELS downstream PWM stages.

Parameters:
- CHANNELS, 4, number of LED channels per frame (>=1).
- DATA_W, 12, brightness word width; matches the downstream counter width.

Ports:
- oscillator  in  1  system clock, rising edge.
- globalResetN  in  1  asynchronous active-low reset.
- dataIn  in  DATA_W  brightness word for the current channel index.
- dataFirst  in  1  qualifies dataIn as channel 0 (start of frame).
- dataValid  in  1  dataIn/dataFirst valid.
- dataReady  out  1  loader can accept a word.
- periodStart  in  1  one-cycle pulse, asserted when the downstream counter wraps to 0.
- clearError  in  1  clears syncError.
- LEDFrameData  out  CHANNELS*DATA_W  active duty values; channel k occupies bits [k*DATA_W +: DATA_W].
- frameSwap  out  1  one-cycle pulse, asserted when the active registers have just been updated.
- framePending  out  1  full frame buffered, waiting for periodStart.
- syncError  out  1  sticky framing-error flag.

Behaviour:
- Reset (globalResetN=0, async):
  - shadow and active registers = 0; LEDFrameData = 0 (all LEDs dark).
  - index = 0, state = FILL.
  - dataReady = 1, frameSwap = 0, framePending = 0, syncError = 0.
- Reset mid-frame discards the partial frame; no swap occurs.
- States: FILL, PENDING.
  - dataReady = (state==FILL), decoded combinationally from the state register.
  - framePending = (state==PENDING).
- Transfer = dataValid & dataReady at a rising edge. dataIn and dataFirst must stay stable while dataValid=1 and dataReady=0.
- FILL, transfer with dataFirst=1:
  - shadow[0] <= dataIn; index <= 1.
  - If index was nonzero, syncError <= 1; the previous partial frame is abandoned.
- FILL, transfer with dataFirst=0:
  - If index != 0: shadow[index] <= dataIn; index <= index+1.
  - If index == 0: word consumed and dropped; syncError <= 1.
- Transfer that writes index CHANNELS-1: index <= 0, state <= PENDING. dataReady is 0 from the next cycle.
  - With CHANNELS=1, every accepted dataFirst word completes a frame.
- PENDING, periodStart=1 at a rising edge:
  - active <= shadow (all channels in the same edge); state <= FILL; frameSwap = 1 for exactly that following cycle.
  - Latency: periodStart edge to new LEDFrameData = 1 edge, registered.
- PENDING, periodStart=0: hold; dataValid is ignored (not consumed).
- FILL, periodStart: no effect; active registers hold.
- Simultaneous events:
  - Last word accepted in the same cycle as periodStart: no swap; the frame swaps at the next periodStart.
  - Error set and clearError in the same cycle: set wins.
- No back-to-back swap: frames arriving faster than periods are throttled by dataReady.
- All outputs are registered except dataReady and framePending (state decode).

Optional Feature:
- Macro: LED_FRAME_COUNT_EN.
- Defined:
  - Adds output frameCount [7:0], reset 0.
  - Increments on every swap and wraps 255 -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, no stimulus -> LEDFrameData=0, dataReady=1, framePending=0, syncError=0; periodStart pulses cause no frameSwap.
- CHANNELS=4; send 0x000 (dataFirst=1), 0x7FF, 0x800, 0xFFF; then periodStart -> framePending=1 after the 4th transfer; one edge after periodStart LEDFrameData={0xFFF,0x800,0x7FF,0x000}, frameSwap high 1 cycle, dataReady=1.
- Full frame buffered; dataValid held high with 0x123 for 10 cycles before periodStart -> dataReady=0, no word consumed, 0x123 is accepted as the first word after the swap.
- Send 0x111 (first), 0x222, then 0x333 with dataFirst=1 -> syncError=1, shadow restarts with 0x333 as channel 0; clearError -> syncError=0.
- Last word transfer coincides with periodStart -> no swap that cycle; swap on the next periodStart, 4096 cycles later.
- globalResetN pulsed low after 2 of 4 words -> outputs return to reset values immediately; the next frame must start with dataFirst. With LED_FRAME_COUNT_EN, 256 swaps -> frameCount returns to 0.
